// File: rtl/vga_scan_timer.sv
// VGA raster generator: pixel-rate enable from the system clock, h/v position counters,
// and registered sync/valid/coordinate outputs that always describe the position held in the counters.
module vga_scan_timer #(
  parameter int CLK_DIV = 4,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_pos;
  logic [9:0]       r_v_pos;

  logic       w_pix_en;
  logic       w_h_wrap;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_valid_nxt;
  logic       w_hsync_nxt;
  logic       w_vsync_nxt;

  assign w_pix_en = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_h_wrap = (r_h_pos == 10'(H_TOTAL - 1));

  always_comb begin
    w_h_nxt = w_h_wrap ? 10'd0 : r_h_pos + 10'd1;
    w_v_nxt = r_v_pos;
    if (w_h_wrap) begin
      w_v_nxt = (r_v_pos == 10'(V_TOTAL - 1)) ? 10'd0 : r_v_pos + 10'd1;
    end
  end

  // Outputs are decoded from the position about to be loaded, so they land together with it.
  assign w_valid_nxt = (w_h_nxt < 10'(H_DISP)) && (w_v_nxt < 10'(V_DISP));
  assign w_hsync_nxt = !((w_h_nxt >= 10'(H_DISP + H_FP)) &&
                         (w_h_nxt <  10'(H_DISP + H_FP + H_SYNC)));
  assign w_vsync_nxt = !((w_v_nxt >= 10'(V_DISP + V_FP)) &&
                         (w_v_nxt <  10'(V_DISP + V_FP + V_SYNC)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_h_pos     <= 10'(H_TOTAL - 1);
      r_v_pos     <= 10'(V_TOTAL - 1);
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      valid       <= 1'b0;
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
    end else begin
      r_div_cnt   <= w_pix_en ? '0 : r_div_cnt + 1'b1;
      pix_tick    <= w_pix_en;
      frame_start <= w_pix_en && (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
      if (w_pix_en) begin
        r_h_pos <= w_h_nxt;
        r_v_pos <= w_v_nxt;
        valid   <= w_valid_nxt;
        h_cnt   <= w_valid_nxt ? w_h_nxt : 10'd0;
        v_cnt   <= w_valid_nxt ? w_v_nxt : 10'd0;
        hsync   <= w_hsync_nxt;
        vsync   <= w_vsync_nxt;
      end
    end
  end

endmodule
